// File: rtl/cnn_mac_pipe_signed_if.sv
// Operand stream in, group-sum stream out, both valid/ready.
// Widths must match the cnn_mac_pipe_signed instance using this bundle.
interface cnn_mac_pipe_signed_if #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 10,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         in_first;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  dout;
  logic [CNT_WIDTH-1:0]         out_count;
  logic                         ovf;

  modport master (
    output in_valid, din0, din1,
    output in_first, in_last, out_ready,
    input  in_ready, out_valid, dout,
    input  out_count, ovf
  );

  modport slave (
    input  in_valid, din0, din1,
    input  in_first, in_last, out_ready,
    output in_ready, out_valid, dout,
    output out_count, ovf
  );
endinterface

// File: rtl/cnn_mac_pipe_signed.sv
// Pipelined signed MAC with first/last grouped accumulation.
// Define CNN_MAC_SAT_EN for saturating accumulate with sticky ovf.
module cnn_mac_pipe_signed #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 10,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input logic ap_clk,
  input logic ap_rst_n,
  cnn_mac_pipe_signed_if.slave s
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LS = NUM_STAGE - 1;

  logic                        en;
  logic signed [PW-1:0]        prod;

  logic signed [PW-1:0]        p_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]        v_q;
  logic [NUM_STAGE-1:0]        f_q;
  logic [NUM_STAGE-1:0]        l_q;

  logic signed [ACC_WIDTH-1:0] pext;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0]        cnt_d;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic                        idle_q;
  logic                        done_q;
  logic                        start;

  logic                        out_valid_q;
  logic signed [ACC_WIDTH-1:0] dout_q;
  logic [CNT_WIDTH-1:0]        count_q;

  // Whole datapath stalls together while a result waits.
  assign en         = !out_valid_q || s.out_ready;
  assign s.in_ready = en;

  // Operands widened first so the product is exact.
  assign prod = PW'(s.din0) * PW'(s.din1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        p_q[i] <= '0;
      end
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else if (en) begin
      p_q[0] <= prod;
      v_q[0] <= s.in_valid;
      f_q[0] <= s.in_valid & s.in_first;
      l_q[0] <= s.in_valid & s.in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        p_q[i] <= p_q[i-1];
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign pext  = ACC_WIDTH'(p_q[LS]);
  assign start = f_q[LS] || idle_q;

`ifdef CNN_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum_w;
  logic                      clamp;
  logic                      ovf_d;
  logic                      ovf_q;
  logic                      ovf_out_q;
`endif

  always_comb begin
    base  = start ? '0 : acc_q;
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_WIDTH'(1);
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
`ifdef CNN_MAC_SAT_EN
    // One guard bit is enough to detect a single-add overflow.
    sum_w = {base[ACC_WIDTH-1], base}
          + {pext[ACC_WIDTH-1], pext};
    clamp = sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1];
    acc_d = sum_w[ACC_WIDTH-1:0];
    if (clamp) begin
      acc_d = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    ovf_d = clamp | (!start & ovf_q);
`else
    acc_d = base + pext;
`endif
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      idle_q <= 1'b1;
      done_q <= 1'b0;
    end else if (en) begin
      done_q <= v_q[LS] & l_q[LS];
      if (v_q[LS]) begin
        acc_q  <= acc_d;
        cnt_q  <= cnt_d;
        idle_q <= l_q[LS];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      count_q     <= '0;
    end else if (en) begin
      out_valid_q <= done_q;
      if (done_q) begin
        dout_q  <= acc_q;
        count_q <= cnt_q;
      end
    end
  end

`ifdef CNN_MAC_SAT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
    end else if (en) begin
      if (v_q[LS]) begin
        ovf_q <= ovf_d;
      end
      if (done_q) begin
        ovf_out_q <= ovf_q;
      end
    end
  end

  assign s.ovf = ovf_out_q;
`else
  assign s.ovf = 1'b0;
`endif

  assign s.out_valid = out_valid_q;
  assign s.dout      = dout_q;
  assign s.out_count = count_q;

endmodule

// File: tb/tb_cnn_mac_pipe_signed.sv
// Directed bench for cnn_mac_pipe_signed (32-bit and 24-bit acc).
// Expectations for the 24-bit case follow CNN_MAC_SAT_EN.
module tb_cnn_mac_pipe_signed;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cnn_mac_pipe_signed_if #(.ACC_WIDTH(32)) bus ();
  cnn_mac_pipe_signed_if #(.ACC_WIDTH(24)) bus2 ();

  cnn_mac_pipe_signed #(.ACC_WIDTH(32)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .s        (bus.slave)
  );

  cnn_mac_pipe_signed #(.ACC_WIDTH(24)) dut24 (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .s        (bus2.slave)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.din0      = bus.din0;
  assign bus2.din1      = bus.din1;
  assign bus2.in_first  = bus.in_first;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int a, input int b,
                       input bit f, input bit l);
    bus.in_valid = 1'b1;
    bus.din0     = 14'(a);
    bus.din1     = 10'(b);
    bus.in_first = f;
    bus.in_last  = l;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 12) begin
      tick();
      n++;
    end
    chk(tag, bus.out_valid, 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.din0 = '0;
    bus.din1 = '0;
    idle();
    tick();
    tick();

    chk("rst in_ready", bus.in_ready, 1);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst dout", bus.dout, 0);
    chk("rst out_count", bus.out_count, 0);
    chk("rst ovf", bus.ovf, 0);
    chk("rst in_ready24", bus2.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // single beat, first=last, latency 4
    drive(-8192, -512, 1, 1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("lat early valid", bus.out_valid, 0);
      tick();
    end
    chk("lat valid", bus.out_valid, 1);
    chk("single dout", bus.dout, 4194304);
    chk("single count", bus.out_count, 1);
    chk("single ovf", bus.ovf, 0);
    tick();
    chk("single retired", bus.out_valid, 0);

    // four-beat group
    drive(100, 3, 1, 0);   tick();
    drive(-50, 7, 0, 0);   tick();
    drive(1, 1, 0, 0);     tick();
    drive(-2, -2, 0, 1);   tick();
    idle();
    wait_out("grp4 timeout");
    chk("grp4 dout", bus.dout, -45);
    chk("grp4 count", bus.out_count, 4);
    tick();

    // stall with 3 beats in flight
    drive(2, 3, 1, 1);     tick();
    drive(1, 1, 1, 0);     tick();
    drive(2, 2, 0, 0);     tick();
    drive(3, 3, 0, 1);     tick();
    idle();
    bus.out_ready = 1'b0;
    tick();
    chk("stall valid", bus.out_valid, 1);
    chk("stall dout0", bus.dout, 6);
    drive(100, 100, 1, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall in_ready", bus.in_ready, 0);
      chk("stall dout", bus.dout, 6);
      chk("stall count", bus.out_count, 1);
      tick();
    end
    idle();
    bus.out_ready = 1'b1;
    tick();
    chk("stall retired", bus.out_valid, 0);
    wait_out("stall timeout");
    chk("post-stall dout", bus.dout, 14);
    chk("post-stall count", bus.out_count, 3);
    tick();
    chk("no dup beat", bus.out_valid, 0);

    // first mid-group discards partial sum
    drive(10, 10, 1, 0);   tick();
    drive(20, 20, 0, 0);   tick();
    drive(5, 5, 1, 1);     tick();
    idle();
    wait_out("restart timeout");
    chk("restart dout", bus.dout, 25);
    chk("restart count", bus.out_count, 1);
    tick();

    // overflow on 24-bit instance
    drive(8191, 511, 1, 0); tick();
    drive(8191, 511, 0, 0); tick();
    drive(8191, 511, 0, 1); tick();
    idle();
    wait_out("ovf timeout");
    chk("wide dout", bus.dout, 12556803);
    chk("wide count", bus.out_count, 3);
    chk("wide ovf", bus.ovf, 0);
    chk("acc24 valid", bus2.out_valid, 1);
    chk("acc24 count", bus2.out_count, 3);
`ifdef CNN_MAC_SAT_EN
    chk("acc24 dout", bus2.dout, 8388607);
    chk("acc24 ovf", bus2.ovf, 1);
`else
    chk("acc24 dout", bus2.dout, -4220413);
    chk("acc24 ovf", bus2.ovf, 0);
`endif
    tick();

    // back-to-back single-beat groups
    drive(1, 2, 1, 1);     tick();
    drive(3, 4, 1, 1);     tick();
    drive(5, 6, 1, 1);     tick();
    idle();
    wait_out("b2b timeout");
    chk("b2b dout0", bus.dout, 2);
    tick();
    chk("b2b valid1", bus.out_valid, 1);
    chk("b2b dout1", bus.dout, 12);
    tick();
    chk("b2b valid2", bus.out_valid, 1);
    chk("b2b dout2", bus.dout, 30);
    tick();
    chk("b2b done", bus.out_valid, 0);

    // reset with beats in flight, then pending result
    drive(7, 7, 1, 0);     tick();
    drive(8, 8, 0, 1);     tick();
    idle();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst valid", bus.out_valid, 0);
    chk("midrst dout", bus.dout, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("midrst dropped", bus.out_valid, 0);
      tick();
    end
    drive(3, 4, 1, 1);     tick();
    idle();
    wait_out("postrst timeout");
    chk("postrst dout", bus.dout, 12);
    chk("postrst count", bus.out_count, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
